// File: rtl/dcache_req_sched.sv
// Data-cache request-port scheduler: PTW priority, load/store round-robin,
// bounded in-flight stores, uncached-load ordering and fence/flush draining.

module dcache_req_sched_chk #(
    parameter int unsigned CntWidth = 3
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic                st_ack_i,
    input logic [CntWidth-1:0] st_cnt
);
    // A retire with nothing outstanding means the write buffer and this block disagree.
    a_ack_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(st_ack_i && (st_cnt == {CntWidth{1'b0}})));
endmodule

module dcache_req_sched #(
    parameter int unsigned          AddrWidth            = 34,
    parameter int unsigned          DataWidth            = 32,
    parameter int unsigned          MaxOutstandingStores = 7,
    parameter logic [AddrWidth-1:0] CachedBase           = 34'h0_8000_0000,
    parameter logic [AddrWidth-1:0] CachedLength         = 34'h0_4000_0000,
    localparam int unsigned         CntWidth             = $clog2(MaxOutstandingStores + 1),
    localparam int unsigned         BeWidth              = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ptw_req_i,
    input  logic [AddrWidth-1:0] ptw_addr_i,
    output logic                 ptw_gnt_o,
    input  logic                 ld_req_i,
    input  logic [AddrWidth-1:0] ld_addr_i,
    output logic                 ld_gnt_o,
    input  logic                 st_req_i,
    input  logic [AddrWidth-1:0] st_addr_i,
    input  logic [DataWidth-1:0] st_wdata_i,
    input  logic [BeWidth-1:0]   st_be_i,
    output logic                 st_gnt_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    output logic [1:0]           mem_src_o,
    input  logic                 mem_gnt_i,
    input  logic                 st_ack_i,
    input  logic                 flush_i,
    output logic                 flush_ack_o,
    output logic [CntWidth-1:0]  st_cnt_o,
    output logic                 busy_o
);

    localparam logic [1:0] SRC_PTW = 2'd0;
    localparam logic [1:0] SRC_LD  = 2'd1;
    localparam logic [1:0] SRC_ST  = 2'd2;

    localparam logic [CntWidth-1:0]  CNT_ZERO   = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0]  CNT_ONE    = CntWidth'(1);
    localparam logic [CntWidth-1:0]  MAX_CNT    = CntWidth'(MaxOutstandingStores);
    localparam logic [AddrWidth:0]   CACHED_LO  = {1'b0, CachedBase};
    localparam logic [AddrWidth:0]   CACHED_END = {1'b0, CachedBase} + {1'b0, CachedLength};

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_DRAIN = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_e;

    function automatic logic is_cached(input logic [AddrWidth-1:0] addr);
        return ({1'b0, addr} >= CACHED_LO) && ({1'b0, addr} < CACHED_END);
    endfunction

    logic                lock_vld_r;
    logic [1:0]          lock_src_r;
    logic                rr_st_r;
    logic [CntWidth-1:0] st_cnt_r;
    logic [CntWidth-1:0] st_cnt_n;
    flush_state_e        state_r;
    flush_state_e        state_n;

    logic       st_elig_s;
    logic       ld_elig_s;
    logic       sel_vld_s;
    logic [1:0] sel_src_s;
    logic       req_s;
    logic       hs_s;
    logic       st_inc_s;
    logic       st_dec_s;
    logic       flush_ack_s;

    // Source selection: a held lock wins, then arbitration only while no drain is in progress.
    // An uncached load must not pass any store, so a competing store always goes first.
    always_comb begin
        st_elig_s = st_req_i && (st_cnt_r < MAX_CNT);
        ld_elig_s = ld_req_i && (is_cached(ld_addr_i) || ((st_cnt_r == CNT_ZERO) && !st_req_i));
        sel_vld_s = 1'b0;
        sel_src_s = SRC_PTW;
        if (lock_vld_r) begin
            sel_vld_s = 1'b1;
            sel_src_s = lock_src_r;
        end else if (state_r != FL_IDLE) begin
            sel_vld_s = 1'b0;
        end else if (ptw_req_i) begin
            sel_vld_s = 1'b1;
            sel_src_s = SRC_PTW;
        end else if (ld_elig_s && st_elig_s) begin
            sel_vld_s = 1'b1;
            sel_src_s = rr_st_r ? SRC_ST : SRC_LD;
        end else if (ld_elig_s) begin
            sel_vld_s = 1'b1;
            sel_src_s = SRC_LD;
        end else if (st_elig_s) begin
            sel_vld_s = 1'b1;
            sel_src_s = SRC_ST;
        end else begin
            sel_vld_s = 1'b0;
        end
    end

    assign req_s     = sel_vld_s & rst_ni;
    assign hs_s      = req_s & mem_gnt_i;
    assign mem_req_o = req_s;
    assign mem_src_o = req_s ? sel_src_s : SRC_PTW;
    assign mem_we_o  = req_s & (sel_src_s == SRC_ST);
    assign ptw_gnt_o = hs_s & (sel_src_s == SRC_PTW);
    assign ld_gnt_o  = hs_s & (sel_src_s == SRC_LD);
    assign st_gnt_o  = hs_s & (sel_src_s == SRC_ST);

    // Port payload mux; store data and byte enables are zero for reads.
    always_comb begin
        mem_addr_o  = {AddrWidth{1'b0}};
        mem_wdata_o = {DataWidth{1'b0}};
        mem_be_o    = {BeWidth{1'b0}};
        if (req_s) begin
            case (sel_src_s)
                SRC_PTW: mem_addr_o = ptw_addr_i;
                SRC_LD:  mem_addr_o = ld_addr_i;
                SRC_ST: begin
                    mem_addr_o  = st_addr_i;
                    mem_wdata_o = st_wdata_i;
                    mem_be_o    = st_be_i;
                end
                default: mem_addr_o = {AddrWidth{1'b0}};
            endcase
        end else begin
            mem_addr_o = {AddrWidth{1'b0}};
        end
    end

    // Lock register: a refused request keeps its slot until the cache accepts it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_vld_r <= 1'b0;
            lock_src_r <= SRC_PTW;
        end else begin
            lock_vld_r <= req_s & ~mem_gnt_i;
            if (req_s && !mem_gnt_i) begin
                lock_src_r <= sel_src_s;
            end
        end
    end

    // Round-robin pointer: favour the other of load/store after each of their handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_st_r <= 1'b0;
        end else if (hs_s && (sel_src_s == SRC_LD)) begin
            rr_st_r <= 1'b1;
        end else if (hs_s && (sel_src_s == SRC_ST)) begin
            rr_st_r <= 1'b0;
        end
    end

    assign st_inc_s = hs_s & (sel_src_s == SRC_ST);
    assign st_dec_s = st_ack_i & (st_cnt_r != CNT_ZERO);

    // Outstanding-store count next value.
    always_comb begin
        st_cnt_n = st_cnt_r;
        case ({st_inc_s, st_dec_s})
            2'b10:   st_cnt_n = st_cnt_r + CNT_ONE;
            2'b01:   st_cnt_n = st_cnt_r - CNT_ONE;
            default: st_cnt_n = st_cnt_r;
        endcase
    end

    // Outstanding-store count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_cnt_r <= CNT_ZERO;
        end else begin
            st_cnt_r <= st_cnt_n;
        end
    end

    // Flush sequencing: drain stores and any lock, acknowledge once, then resume.
    always_comb begin
        state_n     = state_r;
        flush_ack_s = 1'b0;
        case (state_r)
            FL_IDLE: begin
                if (flush_i) begin
                    state_n = FL_DRAIN;
                end else begin
                    state_n = FL_IDLE;
                end
            end
            FL_DRAIN: begin
                if (!flush_i) begin
                    state_n = FL_IDLE;
                end else if ((st_cnt_r == CNT_ZERO) && !lock_vld_r) begin
                    state_n = FL_DONE;
                end else begin
                    state_n = FL_DRAIN;
                end
            end
            FL_DONE: begin
                state_n     = FL_IDLE;
                flush_ack_s = 1'b1;
            end
            default: state_n = FL_IDLE;
        endcase
    end

    // Flush state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= FL_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    assign flush_ack_o = flush_ack_s & rst_ni;
    assign st_cnt_o    = rst_ni ? st_cnt_r : CNT_ZERO;
    assign busy_o      = rst_ni & ((st_cnt_r != CNT_ZERO) | lock_vld_r);

    dcache_req_sched_chk #(
        .CntWidth(CntWidth)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .st_ack_i(st_ack_i),
        .st_cnt  (st_cnt_r)
    );

endmodule

// File: tb/tb_dcache_req_sched.sv
// Self-checking bench for dcache_req_sched: directed scenarios plus a long
// random run compared against a transaction-level reference model.

module tb_dcache_req_sched;

    localparam int AW = 34;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ptw_req_i, ld_req_i, st_req_i;
    logic [AW-1:0] ptw_addr_i, ld_addr_i, st_addr_i;
    logic [DW-1:0] st_wdata_i;
    logic [3:0]    st_be_i;
    logic          mem_gnt_i, st_ack_i, flush_i;
    logic          ptw_gnt_o, ld_gnt_o, st_gnt_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [1:0]    mem_src_o;
    logic          flush_ack_o, busy_o;
    logic [2:0]    st_cnt_o;

    int total = 0;
    int bad   = 0;

    dcache_req_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ptw_req_i(ptw_req_i), .ptw_addr_i(ptw_addr_i), .ptw_gnt_o(ptw_gnt_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i),
        .st_be_i(st_be_i), .st_gnt_o(st_gnt_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_src_o(mem_src_o),
        .mem_gnt_i(mem_gnt_i), .st_ack_i(st_ack_i), .flush_i(flush_i),
        .flush_ack_o(flush_ack_o), .st_cnt_o(st_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: who owns the port, how many stores are in flight, flush phase.
    int  m_cnt, m_lock_src, m_mode;   // m_mode: 0 normal, 1 draining, 2 acknowledging
    bit  m_lock, m_favor_store;
    bit  m_st_ok, m_ld_ok;
    bit  e_req, e_gnt0, e_gnt1, e_gnt2;
    int  e_src;

    function automatic bit in_cached(input logic [AW-1:0] a);
        longint unsigned v;
        v = 64'(a);
        return (v >= 64'h8000_0000) && (v < 64'hC000_0000);
    endfunction

    always_comb begin
        e_req   = 1'b0;
        e_src   = 0;
        m_st_ok = st_req_i && (m_cnt < 7);
        m_ld_ok = ld_req_i && (in_cached(ld_addr_i) || (m_cnt == 0 && !st_req_i));
        if (rst_ni !== 1'b1) begin
            e_req = 1'b0;
        end else if (m_lock) begin
            e_req = 1'b1;
            e_src = m_lock_src;
        end else if (m_mode == 0) begin
            if (ptw_req_i) begin
                e_req = 1'b1; e_src = 0;
            end else if (m_ld_ok && !(m_st_ok && m_favor_store)) begin
                e_req = 1'b1; e_src = 1;
            end else if (m_st_ok) begin
                e_req = 1'b1; e_src = 2;
            end
        end
        e_gnt0 = e_req && mem_gnt_i && (e_src == 0);
        e_gnt1 = e_req && mem_gnt_i && (e_src == 1);
        e_gnt2 = e_req && mem_gnt_i && (e_src == 2);
    end

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_cnt <= 0; m_lock <= 1'b0; m_lock_src <= 0; m_favor_store <= 1'b0; m_mode <= 0;
        end else begin
            m_cnt  <= m_cnt + (e_gnt2 ? 1 : 0) - ((st_ack_i && m_cnt > 0) ? 1 : 0);
            m_lock <= e_req && !mem_gnt_i;
            if (e_req && !mem_gnt_i) m_lock_src <= e_src;
            if (e_gnt1) m_favor_store <= 1'b1;
            else if (e_gnt2) m_favor_store <= 1'b0;
            case (m_mode)
                0: if (flush_i) m_mode <= 1;
                1: if (!flush_i) m_mode <= 0; else if (m_cnt == 0 && !m_lock) m_mode <= 2;
                default: m_mode <= 0;
            endcase
        end
    end

    task automatic clear_inputs;
        ptw_req_i = 0; ld_req_i = 0; st_req_i = 0; mem_gnt_i = 0; st_ack_i = 0; flush_i = 0;
        ptw_addr_i = '0; ld_addr_i = '0; st_addr_i = '0; st_wdata_i = '0; st_be_i = '0;
    endtask

    task automatic do_reset;
        @(negedge clk_i);
        rst_ni = 0;
        clear_inputs();
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        rst_ni = 0; ptw_req_i = 1; ld_req_i = 1; st_req_i = 1; mem_gnt_i = 1;
        ld_addr_i = 34'h0_8000_0000; #1;
        total++;
        if ({mem_req_o, ptw_gnt_o, ld_gnt_o, st_gnt_o, flush_ack_o, busy_o} !== 6'b0)
            begin bad++; $display("FAIL reset_outputs_low got=%b exp=000000",
                {mem_req_o, ptw_gnt_o, ld_gnt_o, st_gnt_o, flush_ack_o, busy_o}); end
        @(negedge clk_i); #1;
        total++;
        if ({mem_req_o, st_cnt_o, busy_o} !== 5'b0)
            begin bad++; $display("FAIL reset_after_edge got=%b exp=00000", {mem_req_o, st_cnt_o, busy_o}); end
        clear_inputs(); rst_ni = 1;
        @(negedge clk_i); #1;
        total++;
        if ({mem_req_o, st_cnt_o, busy_o, flush_ack_o} !== 6'b0)
            begin bad++; $display("FAIL reset_idle got=%b exp=000000", {mem_req_o, st_cnt_o, busy_o, flush_ack_o}); end
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] exp_wd;
        do_reset();
        ld_addr_i = 34'h0_8000_1000; st_addr_i = 34'h0_8000_2000;
        st_wdata_i = $urandom; st_be_i = 4'hA;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            ld_req_i = 1; st_req_i = 1; mem_gnt_i = 1; #1;
            exp_wd = (i % 2 == 1) ? st_wdata_i : '0;
            total++;
            if (mem_req_o !== 1'b1 || mem_src_o !== ((i % 2 == 0) ? 2'd1 : 2'd2))
                begin bad++; $display("FAIL rr_src cycle=%0d got=%0d exp=%0d", i, mem_src_o, (i % 2 == 0) ? 1 : 2); end
            total++;
            if (st_cnt_o !== 3'(i / 2))
                begin bad++; $display("FAIL rr_cnt cycle=%0d got=%0d exp=%0d", i, st_cnt_o, i / 2); end
            total++;
            if (mem_wdata_o !== exp_wd)
                begin bad++; $display("FAIL rr_wdata cycle=%0d got=%h exp=%h", i, mem_wdata_o, exp_wd); end
        end
        @(negedge clk_i);
        ld_req_i = 0; st_req_i = 0; #1;
        total++;
        if (st_cnt_o !== 3'd3) begin bad++; $display("FAIL rr_final_cnt got=%0d exp=3", st_cnt_o); end
    endtask

    task automatic test_ptw_lock;
        do_reset();
        ld_addr_i = 34'h0_8000_0040; ptw_addr_i = 34'h0_9000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            ld_req_i = 1; mem_gnt_i = 0; #1;
            total++;
            if (mem_req_o !== 1'b1 || mem_src_o !== 2'd1 || mem_addr_o !== ld_addr_i || ld_gnt_o !== 1'b0)
                begin bad++; $display("FAIL lock_hold cycle=%0d got_src=%0d got_addr=%h exp_src=1 exp_addr=%h",
                    i, mem_src_o, mem_addr_o, ld_addr_i); end
        end
        @(negedge clk_i);
        ptw_req_i = 1; #1;
        total++;
        if (mem_src_o !== 2'd1 || mem_addr_o !== ld_addr_i || busy_o !== 1'b1)
            begin bad++; $display("FAIL lock_vs_ptw got_src=%0d got_busy=%b exp_src=1 exp_busy=1", mem_src_o, busy_o); end
        @(negedge clk_i);
        mem_gnt_i = 1; #1;
        total++;
        if ({ptw_gnt_o, ld_gnt_o} !== 2'b01 || mem_addr_o !== ld_addr_i)
            begin bad++; $display("FAIL lock_release got=%b exp=01", {ptw_gnt_o, ld_gnt_o}); end
        @(negedge clk_i);
        ld_req_i = 0; #1;
        total++;
        if (mem_src_o !== 2'd0 || ptw_gnt_o !== 1'b1 || mem_addr_o !== ptw_addr_i)
            begin bad++; $display("FAIL ptw_after_lock got_src=%0d got_gnt=%b exp_src=0 exp_gnt=1", mem_src_o, ptw_gnt_o); end
        @(negedge clk_i);
        clear_inputs();
    endtask

    task automatic test_store_cap;
        do_reset();
        st_addr_i = 34'h0_8000_3000; st_wdata_i = 32'hCAFE_0001; st_be_i = 4'hF;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            st_req_i = 1; mem_gnt_i = 1; #1;
            total++;
            if (st_gnt_o !== 1'b1 || st_cnt_o !== 3'(i))
                begin bad++; $display("FAIL cap_fill i=%0d got_gnt=%b got_cnt=%0d exp_gnt=1 exp_cnt=%0d", i, st_gnt_o, st_cnt_o, i); end
        end
        @(negedge clk_i); #1;
        total++;
        if (mem_req_o !== 1'b0 || st_cnt_o !== 3'd7)
            begin bad++; $display("FAIL cap_block got_req=%b got_cnt=%0d exp_req=0 exp_cnt=7", mem_req_o, st_cnt_o); end
        @(negedge clk_i);
        st_ack_i = 1; #1;
        total++;
        if (mem_req_o !== 1'b0) begin bad++; $display("FAIL cap_ack_same_cycle got=%b exp=0", mem_req_o); end
        @(negedge clk_i);
        st_ack_i = 0; #1;
        total++;
        if (st_gnt_o !== 1'b1 || st_cnt_o !== 3'd6)
            begin bad++; $display("FAIL cap_regrant got_gnt=%b got_cnt=%0d exp_gnt=1 exp_cnt=6", st_gnt_o, st_cnt_o); end
        @(negedge clk_i); #1;
        total++;
        if (mem_req_o !== 1'b0 || st_cnt_o !== 3'd7 || busy_o !== 1'b1)
            begin bad++; $display("FAIL cap_refull got_req=%b got_cnt=%0d exp_req=0 exp_cnt=7", mem_req_o, st_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_uncached;
        do_reset();
        st_addr_i = 34'h0_8000_4000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            st_req_i = 1; mem_gnt_i = 1;
        end
        @(negedge clk_i);
        st_req_i = 0; ld_req_i = 1; ld_addr_i = 34'h0_0001_0000; st_ack_i = 1; #1;
        total++;
        if (mem_req_o !== 1'b0 || st_cnt_o !== 3'd2)
            begin bad++; $display("FAIL unc_hold2 got_req=%b got_cnt=%0d exp_req=0 exp_cnt=2", mem_req_o, st_cnt_o); end
        @(negedge clk_i); #1;
        total++;
        if (mem_req_o !== 1'b0 || st_cnt_o !== 3'd1)
            begin bad++; $display("FAIL unc_hold1 got_req=%b got_cnt=%0d exp_req=0 exp_cnt=1", mem_req_o, st_cnt_o); end
        @(negedge clk_i);
        st_ack_i = 0; #1;
        total++;
        if (ld_gnt_o !== 1'b1 || mem_src_o !== 2'd1 || st_cnt_o !== 3'd0)
            begin bad++; $display("FAIL unc_grant got_gnt=%b got_cnt=%0d exp_gnt=1 exp_cnt=0", ld_gnt_o, st_cnt_o); end
        @(negedge clk_i);
        ld_req_i = 0; st_req_i = 1;
        @(negedge clk_i);
        st_req_i = 0; st_ack_i = 1;
        @(negedge clk_i);
        st_ack_i = 0; ld_req_i = 1; st_req_i = 1; #1;
        total++;
        if (mem_src_o !== 2'd2 || {ld_gnt_o, st_gnt_o} !== 2'b01)
            begin bad++; $display("FAIL unc_store_first got_src=%0d got_gnts=%b exp_src=2 exp_gnts=01",
                mem_src_o, {ld_gnt_o, st_gnt_o}); end
        @(negedge clk_i);
        st_req_i = 0; st_ack_i = 1; #1;
        total++;
        if (mem_req_o !== 1'b0) begin bad++; $display("FAIL unc_behind_store got=%b exp=0", mem_req_o); end
        @(negedge clk_i);
        st_ack_i = 0; #1;
        total++;
        if (ld_gnt_o !== 1'b1 || mem_addr_o !== 34'h0_0001_0000)
            begin bad++; $display("FAIL unc_final got_gnt=%b got_addr=%h exp_gnt=1 exp_addr=10000", ld_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        clear_inputs();
    endtask

    task automatic test_flush;
        int pulses;
        pulses = 0;
        do_reset();
        st_addr_i = 34'h0_8000_5000; ptw_addr_i = 34'h0_9000_1000; ld_addr_i = 34'h0_8000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            st_req_i = 1; mem_gnt_i = 1;
        end
        @(negedge clk_i);
        st_req_i = 0; flush_i = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            ptw_req_i = 1; ld_req_i = 1; st_req_i = 1; st_ack_i = (i < 3); #1;
            if (flush_ack_o === 1'b1) pulses++;
            total++;
            if ({mem_req_o, ptw_gnt_o, ld_gnt_o, st_gnt_o} !== 4'b0)
                begin bad++; $display("FAIL flush_no_grant i=%0d got=%b exp=0000", i, {mem_req_o, ptw_gnt_o, ld_gnt_o, st_gnt_o}); end
        end
        total++;
        if (st_cnt_o !== 3'd0) begin bad++; $display("FAIL flush_drained got=%0d exp=0", st_cnt_o); end
        @(negedge clk_i);
        st_ack_i = 0; #1;
        if (flush_ack_o === 1'b1) pulses++;
        total++;
        if (flush_ack_o !== 1'b1) begin bad++; $display("FAIL flush_ack_time got=%b exp=1", flush_ack_o); end
        @(negedge clk_i);
        flush_i = 0; #1;
        if (flush_ack_o === 1'b1) pulses++;
        total++;
        if (ptw_gnt_o !== 1'b1 || mem_src_o !== 2'd0)
            begin bad++; $display("FAIL flush_resume got_gnt=%b got_src=%0d exp_gnt=1 exp_src=0", ptw_gnt_o, mem_src_o); end
        @(negedge clk_i);
        ptw_req_i = 0; #1;
        if (flush_ack_o === 1'b1) pulses++;
        total++;
        if (mem_src_o !== 2'd1 || ld_gnt_o !== 1'b1)
            begin bad++; $display("FAIL flush_resume_rr got_src=%0d exp_src=1", mem_src_o); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL flush_single_pulse got=%0d exp=1", pulses); end
        @(negedge clk_i);
        clear_inputs();
    endtask

    task automatic test_simul_and_reset;
        do_reset();
        st_addr_i = 34'h0_8000_6000; ld_addr_i = 34'h0_8000_0200;
        @(negedge clk_i);
        st_req_i = 1; mem_gnt_i = 1;
        @(negedge clk_i);
        st_ack_i = 1; #1;
        total++;
        if (st_gnt_o !== 1'b1 || st_cnt_o !== 3'd1)
            begin bad++; $display("FAIL simul_setup got_gnt=%b got_cnt=%0d exp_gnt=1 exp_cnt=1", st_gnt_o, st_cnt_o); end
        @(negedge clk_i);
        st_req_i = 0; st_ack_i = 0; mem_gnt_i = 0; ld_req_i = 1; #1;
        total++;
        if (st_cnt_o !== 3'd1) begin bad++; $display("FAIL simul_cnt_unchanged got=%0d exp=1", st_cnt_o); end
        @(negedge clk_i); #1;
        total++;
        if (mem_req_o !== 1'b1 || mem_src_o !== 2'd1 || busy_o !== 1'b1)
            begin bad++; $display("FAIL mid_lock got_req=%b got_busy=%b exp=1,1", mem_req_o, busy_o); end
        rst_ni = 0; #1;
        total++;
        if ({mem_req_o, ld_gnt_o, busy_o} !== 3'b0) begin bad++; $display("FAIL reset_comb got=%b exp=000", {mem_req_o, ld_gnt_o, busy_o}); end
        @(negedge clk_i);
        ld_req_i = 0; rst_ni = 1; #1;
        total++;
        if ({mem_req_o, st_cnt_o, busy_o} !== 5'b0)
            begin bad++; $display("FAIL reset_mid_lock got=%b exp=00000", {mem_req_o, st_cnt_o, busy_o}); end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 5))
            0:       a = 34'h0_8000_0000 + 34'($urandom_range(0, 32'h3FFF_FFFF));
            1:       a = 34'h0_0001_0000 + 34'($urandom_range(0, 255));
            2:       a = 34'h0_BFFF_FFFC;
            3:       a = 34'h0_C000_0000;
            4:       a = {2'b11, 32'($urandom)};
            default: a = 34'h0_7FFF_FFFC;
        endcase
        return a;
    endfunction

    task automatic test_random;
        bit p_ptw, p_ld, p_st, p_fack;
        logic [11:0] got_v, exp_v;
        logic [AW+DW+3:0] got_d, exp_d;
        logic [AW-1:0] ea;
        p_ptw = 0; p_ld = 0; p_st = 0; p_fack = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            if (!ptw_req_i || p_ptw) begin ptw_req_i = ($urandom_range(0, 5) == 0); ptw_addr_i = rand_addr(); end
            if (!ld_req_i || p_ld) begin ld_req_i = $urandom_range(0, 1); ld_addr_i = rand_addr(); end
            if (!st_req_i || p_st) begin
                st_req_i = $urandom_range(0, 1); st_addr_i = rand_addr();
                st_wdata_i = $urandom; st_be_i = 4'($urandom);
            end
            st_ack_i  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            if (flush_i && p_fack) flush_i = 0;
            else if (!flush_i && $urandom_range(0, 39) == 0) flush_i = 1;
            #1;
            got_v = {mem_req_o, mem_we_o, mem_req_o ? mem_src_o : 2'b00, ptw_gnt_o, ld_gnt_o, st_gnt_o,
                     flush_ack_o, st_cnt_o, busy_o};
            exp_v = {e_req, e_req && (e_src == 2), e_req ? 2'(e_src) : 2'b00, e_gnt0, e_gnt1, e_gnt2,
                     (m_mode == 2), 3'(m_cnt), (m_cnt != 0) || m_lock};
            total++;
            if (got_v !== exp_v) begin bad++; $display("FAIL rand_ctrl cycle=%0d got=%b exp=%b", c, got_v, exp_v); end
            if (e_req) begin
                ea = (e_src == 0) ? ptw_addr_i : (e_src == 1) ? ld_addr_i : st_addr_i;
                got_d = {mem_addr_o, mem_wdata_o, mem_be_o};
                exp_d = {ea, (e_src == 2) ? st_wdata_i : 32'h0, (e_src == 2) ? st_be_i : 4'h0};
                total++;
                if (got_d !== exp_d) begin bad++; $display("FAIL rand_data cycle=%0d got=%h exp=%h", c, got_d, exp_d); end
            end
            p_ptw = e_gnt0; p_ld = e_gnt1; p_st = e_gnt2; p_fack = (m_mode == 2);
        end
        @(negedge clk_i);
        clear_inputs();
    endtask

    initial begin
        rst_ni = 0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_ptw_lock();
        test_store_cap();
        test_uncached();
        test_flush();
        test_simul_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
